// File: rtl/cosim_stream_checker.sv
// cosim_stream_checker: buffers a golden and a DUT stream and compares them word by word
module cosim_stream_checker #(
    parameter int W = 11,
    parameter int DEPTH = 8,
    parameter int TIMEOUT = 1023,
    parameter int STOP_ON_ERR = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         enable,
    input  logic         gold_valid,
    output logic         gold_ready,
    input  logic [W-1:0] gold_data,
    input  logic         dut_valid,
    output logic         dut_ready,
    input  logic [W-1:0] dut_data,
    output logic [15:0]  match_count,
    output logic [15:0]  mismatch_count,
    output logic         first_err_valid,
    output logic [W-1:0] first_err_gold,
    output logic [W-1:0] first_err_dut,
    output logic [15:0]  first_err_index,
    output logic         timeout,
    output logic [1:0]   state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALT_ERR, HALT_TO} state_t;

    state_t st, st_nxt;
    logic [W-1:0] gmem [DEPTH];
    logic [W-1:0] dmem [DEPTH];
    logic [AW-1:0] gwp, grp, dwp, drp;
    logic [AW:0] gcnt, dcnt;
    logic [LW-1:0] lag;
    logic [15:0] idx;
    logic active, gpush, dpush, cmp, mis, lag_hit;

    assign active = st == RUN || (st == HALT_ERR && STOP_ON_ERR == 0);
    assign gpush = gold_valid && gold_ready;
    assign dpush = dut_valid && dut_ready;
    assign cmp = active && gcnt != '0 && dcnt != '0;
    assign mis = cmp && gmem[grp] != dmem[drp];
    // Lag only grows while exactly one side holds data; reaching the limit halts.
    assign lag_hit = active && ((gcnt != '0) != (dcnt != '0)) && lag == LW'(TIMEOUT - 1);

    always_ff @(posedge CLK) begin
        st <= RESET ? IDLE : st_nxt;
    end

    always_comb begin
        st_nxt = (st == IDLE) ? (enable ? RUN : IDLE) :
                 (st == HALT_TO || lag_hit) ? HALT_TO :
                 (st == RUN && mis) ? HALT_ERR : st;
    end

    always_comb begin
        gold_ready = active && gcnt != FULL;
        dut_ready = active && dcnt != FULL;
        timeout = st == HALT_TO;
        state = st;
    end

    always_ff @(posedge CLK) begin
        if (gpush) gmem[gwp] <= gold_data;
        if (dpush) dmem[dwp] <= dut_data;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            gwp <= '0;
            grp <= '0;
            dwp <= '0;
            drp <= '0;
            gcnt <= '0;
            dcnt <= '0;
            lag <= '0;
            idx <= '0;
            match_count <= '0;
            mismatch_count <= '0;
            first_err_valid <= 1'b0;
            first_err_gold <= '0;
            first_err_dut <= '0;
            first_err_index <= '0;
        end else begin
            gwp <= gwp + AW'(gpush);
            dwp <= dwp + AW'(dpush);
            grp <= grp + AW'(cmp);
            drp <= drp + AW'(cmp);
            gcnt <= gcnt + (AW+1)'(gpush) - (AW+1)'(cmp);
            dcnt <= dcnt + (AW+1)'(dpush) - (AW+1)'(cmp);
            if (cmp || (gcnt == '0 && dcnt == '0)) lag <= '0;
            else if (active) lag <= lag + LW'(1);
            if (cmp) begin
                idx <= idx + 16'd1;
                if (!mis && match_count != 16'hFFFF) match_count <= match_count + 16'd1;
                if (mis && mismatch_count != 16'hFFFF) mismatch_count <= mismatch_count + 16'd1;
                if (mis && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_gold <= gmem[grp];
                    first_err_dut <= dmem[drp];
                    first_err_index <= idx;
                end
            end
        end
    end
endmodule

// File: tb/tb_cosim_stream_checker.sv
// tb_cosim_stream_checker: directed tests on three checker configurations sharing one stimulus bus
module tb_cosim_stream_checker;
    logic clk, rst, en, gv, dv;
    logic [10:0] gd, dd;
    logic gr [3];
    logic dr [3];
    logic [15:0] mc [3];
    logic [15:0] mmc [3];
    logic [15:0] fei [3];
    logic fev [3];
    logic [10:0] feg [3];
    logic [10:0] fed [3];
    logic to [3];
    logic [1:0] st [3];
    int checks, fails;

    // 0: defaults, 1: STOP_ON_ERR=0, 2: TIMEOUT=10
    for (genvar i = 0; i < 3; i++) begin : g
        cosim_stream_checker #(
            .W(11), .DEPTH(8),
            .TIMEOUT(i == 2 ? 10 : 1023),
            .STOP_ON_ERR(i == 1 ? 0 : 1)
        ) u (
            .CLK(clk), .RESET(rst), .enable(en),
            .gold_valid(gv), .gold_ready(gr[i]), .gold_data(gd),
            .dut_valid(dv), .dut_ready(dr[i]), .dut_data(dd),
            .match_count(mc[i]), .mismatch_count(mmc[i]),
            .first_err_valid(fev[i]), .first_err_gold(feg[i]), .first_err_dut(fed[i]),
            .first_err_index(fei[i]), .timeout(to[i]), .state(st[i])
        );
    end

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic start();
        rst = 1; en = 0; gv = 0; dv = 0;
        @(negedge clk);
        rst = 0; en = 1;
        @(negedge clk);
        en = 0;
    endtask

    task automatic stream(input int s, input int dly, input int bad1, input int bad2,
                          input bit chk_ready, output bit saw_full);
        int gi, di, dw, gc, dc, cyc;
        bit gp, dp, c;
        gi = 1; di = 1; dw = 0; gc = 0; dc = 0; cyc = 0; saw_full = 0;
        while ((gi <= 20 || di <= 20) && cyc < 300) begin
            gv = gi <= 20;
            gd = 11'(gi);
            dv = di <= 20 && dw == 0;
            dd = (di == bad1 || di == bad2) ? 11'd99 : 11'(di);
            gp = gv && gr[s];
            dp = dv && dr[s];
            if (chk_ready) begin
                checks++;
                if (gr[s] !== (gc < 8) || dr[s] !== (dc < 8)) begin
                    fails++;
                    $display("FAIL ready cyc=%0d got g=%b d=%b exp g=%b d=%b", cyc, gr[s], dr[s], gc < 8, dc < 8);
                end
                if (!gr[s]) saw_full = 1;
            end
            c = gc > 0 && dc > 0;
            @(negedge clk);
            gc += int'(gp) - int'(c);
            dc += int'(dp) - int'(c);
            if (gp) gi++;
            if (dp) begin di++; dw = dly - 1; end
            else if (dw > 0) dw--;
            cyc++;
        end
        gv = 0; dv = 0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; en = 0; gv = 1; dv = 1; gd = 3; dd = 3;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (st[s] !== 2'd0 || to[s] !== 1'b0 || gr[s] !== 1'b0 || dr[s] !== 1'b0) begin
                fails++;
                $display("FAIL reset_ctrl[%0d] got st=%0d to=%b gr=%b dr=%b exp 0 0 0 0", s, st[s], to[s], gr[s], dr[s]);
            end
            checks++;
            if (mc[s] !== 16'd0 || mmc[s] !== 16'd0 || fev[s] !== 1'b0 || feg[s] !== 11'd0 || fed[s] !== 11'd0 || fei[s] !== 16'd0) begin
                fails++;
                $display("FAIL reset_data[%0d] got mc=%0d mmc=%0d fev=%b feg=%0d fed=%0d fei=%0d exp all 0", s, mc[s], mmc[s], fev[s], feg[s], fed[s], fei[s]);
            end
        end
        rst = 0;
        @(negedge clk);
        checks++;
        if (st[0] !== 2'd0) begin
            fails++;
            $display("FAIL idle_hold got st=%0d exp 0", st[0]);
        end
        gv = 0; dv = 0;
    endtask

    task automatic test_unskewed();
        bit sf;
        start();
        checks++;
        if (st[0] !== 2'd1) begin fails++; $display("FAIL enable got st=%0d exp 1", st[0]); end
        stream(0, 1, 0, 0, 0, sf);
        checks++;
        if (mc[0] !== 16'd20 || mmc[0] !== 16'd0) begin
            fails++;
            $display("FAIL unskewed_counts got mc=%0d mmc=%0d exp 20 0", mc[0], mmc[0]);
        end
        checks++;
        if (st[0] !== 2'd1 || to[0] !== 1'b0 || fev[0] !== 1'b0 || gr[0] !== 1'b1 || dr[0] !== 1'b1) begin
            fails++;
            $display("FAIL unskewed_state got st=%0d to=%b fev=%b gr=%b dr=%b exp 1 0 0 1 1", st[0], to[0], fev[0], gr[0], dr[0]);
        end
    endtask

    task automatic test_skew();
        bit sf;
        start();
        stream(0, 5, 0, 0, 1, sf);
        checks++;
        if (sf !== 1'b1) begin fails++; $display("FAIL skew_full got saw_full=%b exp 1", sf); end
        checks++;
        if (mc[0] !== 16'd20 || mmc[0] !== 16'd0 || to[0] !== 1'b0 || st[0] !== 2'd1) begin
            fails++;
            $display("FAIL skew_final got mc=%0d mmc=%0d to=%b st=%0d exp 20 0 0 1", mc[0], mmc[0], to[0], st[0]);
        end
    endtask

    task automatic test_stop_on_err();
        bit sf;
        start();
        stream(0, 1, 7, 0, 0, sf);
        checks++;
        if (fev[0] !== 1'b1 || feg[0] !== 11'd7 || fed[0] !== 11'd99 || fei[0] !== 16'd6) begin
            fails++;
            $display("FAIL stop_capture got fev=%b gold=%0d dut=%0d idx=%0d exp 1 7 99 6", fev[0], feg[0], fed[0], fei[0]);
        end
        checks++;
        if (st[0] !== 2'd2 || gr[0] !== 1'b0 || dr[0] !== 1'b0) begin
            fails++;
            $display("FAIL stop_halt got st=%0d gr=%b dr=%b exp 2 0 0", st[0], gr[0], dr[0]);
        end
        checks++;
        if (mc[0] !== 16'd6 || mmc[0] !== 16'd1) begin
            fails++;
            $display("FAIL stop_counts got mc=%0d mmc=%0d exp 6 1", mc[0], mmc[0]);
        end
    endtask

    task automatic test_continue();
        bit sf;
        start();
        stream(1, 1, 7, 12, 0, sf);
        checks++;
        if (mc[1] !== 16'd18 || mmc[1] !== 16'd2) begin
            fails++;
            $display("FAIL cont_counts got mc=%0d mmc=%0d exp 18 2", mc[1], mmc[1]);
        end
        checks++;
        if (feg[1] !== 11'd7 || fed[1] !== 11'd99 || fei[1] !== 16'd6 || st[1] !== 2'd2) begin
            fails++;
            $display("FAIL cont_capture got gold=%0d dut=%0d idx=%0d st=%0d exp 7 99 6 2", feg[1], fed[1], fei[1], st[1]);
        end
    endtask

    task automatic test_timeout();
        start();
        gv = 1; gd = 11'd5;
        @(negedge clk);
        gv = 0;
        repeat (9) @(negedge clk);
        checks++;
        if (st[2] !== 2'd1 || to[2] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_early got st=%0d to=%b exp 1 0", st[2], to[2]);
        end
        @(negedge clk);
        checks++;
        if (st[2] !== 2'd3 || to[2] !== 1'b1 || gr[2] !== 1'b0 || dr[2] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_hit got st=%0d to=%b gr=%b dr=%b exp 3 1 0 0", st[2], to[2], gr[2], dr[2]);
        end
        en = 1; dv = 1; dd = 11'd5;
        repeat (5) @(negedge clk);
        en = 0; dv = 0;
        checks++;
        if (st[2] !== 2'd3 || mc[2] !== 16'd0) begin
            fails++;
            $display("FAIL timeout_terminal got st=%0d mc=%0d exp 3 0", st[2], mc[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit sf;
        start();
        for (int i = 0; i < 3; i++) begin
            gv = 1; gd = 11'(50 + i);
            dv = i == 2; dd = 11'd60;
            @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        gv = 0; dv = 0;
        checks++;
        if (st[0] !== 2'd0 || mc[0] !== 16'd0 || mmc[0] !== 16'd0 || fev[0] !== 1'b0 || gr[0] !== 1'b0 || dr[0] !== 1'b0) begin
            fails++;
            $display("FAIL midreset got st=%0d mc=%0d mmc=%0d fev=%b gr=%b dr=%b exp all 0", st[0], mc[0], mmc[0], fev[0], gr[0], dr[0]);
        end
        rst = 0; en = 1;
        @(negedge clk);
        en = 0;
        stream(0, 1, 2, 0, 0, sf);
        checks++;
        if (fei[0] !== 16'd1 || feg[0] !== 11'd2 || fed[0] !== 11'd99 || mc[0] !== 16'd1 || mmc[0] !== 16'd1) begin
            fails++;
            $display("FAIL midreset_fresh got idx=%0d gold=%0d dut=%0d mc=%0d mmc=%0d exp 1 2 99 1 1", fei[0], feg[0], fed[0], mc[0], mmc[0]);
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst = 1; en = 0; gv = 0; dv = 0; gd = 0; dd = 0;
        @(negedge clk);
        test_reset();
        test_unskewed();
        test_skew();
        test_stop_on_err();
        test_continue();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
